// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: op classes, op codes, FSM states
// and the op-decode helper used by the top and the lane aligner.
package mem_access_unit_pkg;

    localparam logic AVAIL   = 1'b1;
    localparam logic UNAVAIL = 1'b0;

    localparam logic [2:0] ALUSEL_OTHER = 3'd0;
    localparam logic [2:0] ALUSEL_LOAD  = 3'd1;
    localparam logic [2:0] ALUSEL_STORE = 3'd2;

    localparam logic [6:0] OP_LB  = 7'h10;
    localparam logic [6:0] OP_LH  = 7'h11;
    localparam logic [6:0] OP_LW  = 7'h12;
    localparam logic [6:0] OP_LBU = 7'h14;
    localparam logic [6:0] OP_LHU = 7'h15;
    localparam logic [6:0] OP_SB  = 7'h18;
    localparam logic [6:0] OP_SH  = 7'h19;
    localparam logic [6:0] OP_SW  = 7'h1A;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] ZEROWORD = '0;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } mem_size_e;

    typedef struct packed {
        mem_size_e size;
        logic      is_unsigned;
    } mem_op_t;

    // Unknown codes fall back to a signed word access.
    function automatic mem_op_t decode_op(input logic [6:0] aluop);
        mem_op_t d;
        d.size        = SzWord;
        d.is_unsigned = 1'b0;
        case (aluop)
            OP_LB, OP_SB: d.size = SzByte;
            OP_LH, OP_SH: d.size = SzHalf;
            OP_LBU: begin
                d.size        = SzByte;
                d.is_unsigned = 1'b1;
            end
            OP_LHU: begin
                d.size        = SzHalf;
                d.is_unsigned = 1'b1;
            end
            default: d.size = SzWord;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mau_align.sv
// Byte-lane alignment: store lane enables and data replication, load shift and extension.
module mau_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  mem_size_e                   size_i,
    input  logic                        is_unsigned_i,
    input  logic [$clog2(XLEN/8)-1:0]   offset_i,
    input  logic [XLEN-1:0]             st_data_i,
    output logic [XLEN/8-1:0]           st_byte_o,
    output logic [XLEN-1:0]             st_wdata_o,
    input  logic [XLEN-1:0]             ld_rdata_i,
    output logic [XLEN-1:0]             ld_result_o
);
    localparam int unsigned NB = XLEN / 8;

    logic [NB-1:0]   base_mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        base_mask  = NB'(15);
        st_wdata_o = {(NB/4){st_data_i[31:0]}};
        case (size_i)
            SzByte: begin
                base_mask  = NB'(1);
                st_wdata_o = {NB{st_data_i[7:0]}};
            end
            SzHalf: begin
                base_mask  = NB'(3);
                st_wdata_o = {(NB/2){st_data_i[15:0]}};
            end
            default: begin
                base_mask  = NB'(15);
                st_wdata_o = {(NB/4){st_data_i[31:0]}};
            end
        endcase
        st_byte_o = base_mask << offset_i;
    end

    always_comb begin
        shifted = ld_rdata_i >> {offset_i, 3'b000};
        case (size_i)
            SzByte:  ld_result_o = is_unsigned_i ? XLEN'(shifted[7:0])
                                                 : XLEN'($signed(shifted[7:0]));
            SzHalf:  ld_result_o = is_unsigned_i ? XLEN'(shifted[15:0])
                                                 : XLEN'($signed(shifted[15:0]));
            default: ld_result_o = XLEN'($signed(shifted[31:0]));
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Registered memory stage: accepts one EX op, runs a req/ack RAM access with an optional
// timeout, and hands a single registered writeback beat to WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REGW    = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wvalid,
    input  logic [REGW-1:0]   in_waddr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [2:0]        in_alusel,
    input  logic [6:0]        in_aluop,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_r2,
    output logic              ram_req,
    output logic              ram_write,
    output logic [XLEN/8-1:0] ram_byte,
    output logic [XLEN-1:0]   ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic              ram_ack,
    input  logic [XLEN-1:0]   ram_rdata,
    output logic              out_valid,
    output logic              out_wvalid,
    output logic [REGW-1:0]   out_waddr,
    output logic [XLEN-1:0]   out_wdata,
    output logic              stall,
    output logic              exc_misalign,
    output logic              exc_timeout,
    output logic [XLEN-1:0]   exc_addr
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]      state_q, state_d;
    logic            wvalid_q, wvalid_d;
    logic [REGW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] r2_q, r2_d;
    mem_size_e       size_q, size_d;
    logic            uns_q, uns_d;
    logic            store_q, store_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            mis_q, mis_d;
    logic            to_q, to_d;
    logic [XLEN-1:0] exc_addr_q, exc_addr_d;

    mem_op_t         in_op;
    logic            in_is_mem, in_is_store, in_mis, timeout_hit;
    logic            in_req, in_done;
    logic [NB-1:0]   st_byte;
    logic [XLEN-1:0] st_wdata, ld_result;

    mau_align #(
        .XLEN(XLEN)
    ) u_align (
        .size_i        (size_q),
        .is_unsigned_i (uns_q),
        .offset_i      (addr_q[OFFW-1:0]),
        .st_data_i     (r2_q),
        .st_byte_o     (st_byte),
        .st_wdata_o    (st_wdata),
        .ld_rdata_i    (ram_rdata),
        .ld_result_o   (ld_result)
    );

    always_comb begin
        in_op       = decode_op(in_aluop);
        in_is_store = (in_alusel == ALUSEL_STORE);
        in_is_mem   = (in_alusel == ALUSEL_LOAD) || in_is_store;
        in_mis      = ((in_op.size == SzHalf) && in_addr[0]) ||
                      ((in_op.size == SzWord) && (in_addr[1:0] != 2'b00));
        // Fires on the TIMEOUT-th cycle of REQ, so ram_req is high for exactly TIMEOUT cycles.
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNTW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d    = state_q;
        wvalid_d   = wvalid_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        r2_d       = r2_q;
        size_d     = size_q;
        uns_d      = uns_q;
        store_d    = store_q;
        cnt_d      = cnt_q;
        mis_d      = mis_q;
        to_d       = to_q;
        exc_addr_d = exc_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    waddr_d  = in_waddr;
                    wdata_d  = in_wdata;
                    addr_d   = in_addr;
                    r2_d     = in_r2;
                    size_d   = in_op.size;
                    uns_d    = in_op.is_unsigned;
                    store_d  = in_is_store;
                    cnt_d    = '0;
                    mis_d    = 1'b0;
                    to_d     = 1'b0;
                    wvalid_d = in_wvalid && (in_waddr != '0);
                    if (!in_is_mem) begin
                        state_d = ST_DONE;
                    end else if (in_mis) begin
                        state_d    = ST_DONE;
                        mis_d      = 1'b1;
                        exc_addr_d = in_addr;
                        wvalid_d   = 1'b0;
                    end else begin
                        state_d = ST_REQ;
                        if (in_is_store) begin
                            wvalid_d = 1'b0;
                        end
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (ram_ack) begin
                    if (!store_q) begin
                        wdata_d = ld_result;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    to_d       = 1'b1;
                    exc_addr_d = addr_q;
                    wvalid_d   = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wvalid_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            r2_q       <= '0;
            size_q     <= SzByte;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            cnt_q      <= '0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wvalid_q   <= wvalid_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            r2_q       <= r2_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            store_q    <= store_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            to_q       <= to_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // RAM outputs come straight from registered state, so they hold steady until ack.
    always_comb begin
        in_req       = (state_q == ST_REQ);
        in_done      = (state_q == ST_DONE);
        in_ready     = (state_q == ST_IDLE) ? AVAIL : UNAVAIL;
        stall        = ~in_ready;
        ram_req      = in_req;
        ram_write    = in_req && store_q;
        ram_byte     = in_req ? st_byte : '0;
        ram_addr     = in_req ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : ZEROWORD[XLEN-1:0];
        ram_wdata    = in_req ? st_wdata : ZEROWORD[XLEN-1:0];
        out_valid    = in_done;
        out_wvalid   = in_done && wvalid_q;
        out_waddr    = waddr_q;
        out_wdata    = wdata_q;
        exc_misalign = in_done && mis_q;
        exc_timeout  = in_done && to_q;
        exc_addr     = exc_addr_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level memory model predicts writeback beats
// and RAM requests; a RAM responder and an output monitor check them independently.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REGW    = 5;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned MEMB    = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0, in_ready, in_wvalid = 1'b0;
    logic [4:0]      in_waddr = '0;
    logic [31:0]     in_wdata = '0, in_addr = '0, in_r2 = '0;
    logic [2:0]      in_alusel = '0;
    logic [6:0]      in_aluop = '0;
    logic            ram_req, ram_write, ram_ack;
    logic [3:0]      ram_byte;
    logic [31:0]     ram_addr, ram_wdata, ram_rdata;
    logic            out_valid, out_wvalid, stall, exc_misalign, exc_timeout;
    logic [4:0]      out_waddr;
    logic [31:0]     out_wdata, exc_addr;

    always #5 clk = ~clk;

    mem_access_unit #(
        .XLEN(XLEN), .REGW(REGW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_wvalid(in_wvalid), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .in_alusel(in_alusel), .in_aluop(in_aluop), .in_addr(in_addr), .in_r2(in_r2),
        .ram_req(ram_req), .ram_write(ram_write), .ram_byte(ram_byte), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_wvalid(out_wvalid), .out_waddr(out_waddr),
        .out_wdata(out_wdata), .stall(stall), .exc_misalign(exc_misalign),
        .exc_timeout(exc_timeout), .exc_addr(exc_addr)
    );

    typedef struct {
        logic        wvalid;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        bit          chk_data;
        logic        mis;
        logic        to;
        logic [31:0] exc_addr;
        bit          is_mem;
        int          acc_cyc;
    } exp_out_t;

    // delay: ack on request cycle delay+1; -1 = never ack (timeout); -2 = abandoned by reset.
    typedef struct {
        logic        write;
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
    } exp_req_t;

    exp_out_t    out_q[$];
    exp_req_t    req_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        ack_seen = 1'b0;
    logic [7:0]  mdl_mem [MEMB];
    logic [31:0] ram_mem [MEMB/4];
    logic [31:0] mdl_exc_addr = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ack_seen <= ram_ack;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        vectors++;
        miscompares++;
        $display("FAIL %s: waited %0d cycles without the expected event", name, waited);
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        ram_mem[a[8:2]] = w;
        for (int k = 0; k < 4; k++) mdl_mem[a + k] = 8'(w >> (8 * k));
    endtask

    task automatic issue(input logic [2:0] sel, input logic [6:0] op, input logic wv,
                         input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] a,
                         input logic [31:0] r2, input int delay, input bit track);
        exp_out_t    e;
        exp_req_t    r;
        int          n, g;
        bit          uns, is_ld, is_st;
        logic [31:0] v;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            bound_fail("in_ready_wait", g);
            return;
        end
        is_ld = (sel == ALUSEL_LOAD);
        is_st = (sel == ALUSEL_STORE);
        n = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
            (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        uns = (op == OP_LBU || op == OP_LHU);
        e.mis      = (is_ld || is_st) && ((a % n) != 0);
        e.is_mem   = (is_ld || is_st) && !e.mis;
        e.to       = e.is_mem && (delay == -1);
        e.waddr    = wa;
        e.wvalid   = wv && (wa != 0) && !is_st && !e.mis && !e.to;
        e.chk_data = 1'b0;
        e.wdata    = '0;
        if (!is_ld && !is_st) begin
            e.wdata    = wd;
            e.chk_data = 1'b1;
        end else if (is_ld && e.is_mem && !e.to) begin
            v = '0;
            for (int k = 0; k < n; k++) v = v | (32'(mdl_mem[a + k]) << (8 * k));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.wdata    = v;
            e.chk_data = 1'b1;
        end else if (is_st && e.is_mem && !e.to && delay >= 0) begin
            for (int k = 0; k < n; k++) mdl_mem[a + k] = 8'(r2 >> (8 * k));
        end
        if (e.mis || e.to) mdl_exc_addr = a;
        e.exc_addr = mdl_exc_addr;
        e.acc_cyc  = cyc + 1;
        r.write    = is_st;
        r.addr     = a - (a % 4);
        r.byte_en  = 4'(((1 << n) - 1) << (a % 4));
        r.wdata    = (n == 1) ? {4{r2[7:0]}} : (n == 2) ? {2{r2[15:0]}} : r2;
        r.delay    = delay;
        if (track) out_q.push_back(e);
        if (e.is_mem) req_q.push_back(r);
        in_valid  = 1'b1;
        in_alusel = sel;
        in_aluop  = op;
        in_wvalid = wv;
        in_waddr  = wa;
        in_wdata  = wd;
        in_addr   = a;
        in_r2     = r2;
        @(negedge clk);
        in_valid  = 1'b0;
        in_wdata  = $urandom;
        in_addr   = $urandom;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((out_q.size() != 0 || !in_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (out_q.size() != 0 || !in_ready) bound_fail("drain", g);
        check("req_queue_empty", 64'(req_q.size()), 64'd0);
    endtask

    task automatic random_op();
        int          kind, n, d, w;
        logic [6:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        d    = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
        if (kind < 3) begin
            issue(ALUSEL_OTHER, 7'h7F, 1'($urandom), 5'($urandom), $urandom, $urandom,
                  $urandom, 0, 1'b1);
            return;
        end
        if (kind < 7) begin
            sel = ALUSEL_LOAD;
            case ($urandom_range(0, 4))
                0:       op = OP_LB;
                1:       op = OP_LBU;
                2:       op = OP_LH;
                3:       op = OP_LHU;
                default: op = OP_LW;
            endcase
        end else begin
            sel = ALUSEL_STORE;
            case ($urandom_range(0, 2))
                0:       op = OP_SB;
                1:       op = OP_SH;
                default: op = OP_SW;
            endcase
        end
        n = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
            (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        w = $urandom_range(0, 127);
        if ($urandom_range(0, 3) != 0) a = 32'(w * 4 + n * $urandom_range(0, 4 / n - 1));
        else a = 32'(w * 4 + $urandom_range(0, 3));
        issue(sel, op, 1'($urandom), 5'($urandom), $urandom, a, $urandom, d, 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // RAM responder: checks each request against the model, then acks after its delay.
    initial begin
        int       rc;
        bit       have;
        exp_req_t cur;
        rc = 0;
        have = 1'b0;
        ram_ack = 1'b0;
        ram_rdata = '0;
        forever begin
            @(negedge clk);
            ram_ack   = 1'b0;
            ram_rdata = $urandom;
            if (!rst) begin
                rc = 0;
                have = 1'b0;
            end else if (ram_req) begin
                rc++;
                if (rc == 1) begin
                    if (req_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ram_req: got addr 0x%0h, want no request",
                                 ram_addr);
                        have = 1'b0;
                    end else begin
                        cur = req_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    check("ram_write", 64'(ram_write), 64'(cur.write));
                    check("ram_addr", 64'(ram_addr), 64'(cur.addr));
                    check("ram_byte", 64'(ram_byte), 64'(cur.byte_en));
                    if (cur.write) check("ram_wdata", 64'(ram_wdata), 64'(cur.wdata));
                    if (cur.delay >= 0 && rc == cur.delay + 1) begin
                        ram_rdata = ram_mem[ram_addr[8:2]];
                        if (ram_write) begin
                            for (int b = 0; b < 4; b++) begin
                                if (ram_byte[b]) ram_mem[ram_addr[8:2]][8*b +: 8] = ram_wdata[8*b +: 8];
                            end
                        end
                        ram_ack = 1'b1;
                    end
                end
            end else begin
                if (rc > 0 && have && cur.delay == -1) check("timeout_req_cycles", 64'(rc),
                                                              64'(TIMEOUT));
                rc = 0;
                have = 1'b0;
            end
        end
    end

    // Output monitor: every writeback beat must match the oldest outstanding expectation.
    initial begin
        exp_out_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (out_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, want 0");
                end else begin
                    e = out_q.pop_front();
                    check("out_wvalid", 64'(out_wvalid), 64'(e.wvalid));
                    check("out_waddr", 64'(out_waddr), 64'(e.waddr));
                    if (e.chk_data) check("out_wdata", 64'(out_wdata), 64'(e.wdata));
                    check("exc_misalign", 64'(exc_misalign), 64'(e.mis));
                    check("exc_timeout", 64'(exc_timeout), 64'(e.to));
                    check("exc_addr", 64'(exc_addr), 64'(e.exc_addr));
                    check("stall_in_done", 64'(stall), 64'd1);
                    if (e.is_mem) check("ack_precedes_out", 64'(ack_seen), 64'(!e.to));
                    else check("nonmem_latency", 64'(cyc - e.acc_cyc), 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(MEMB / 4); i++) set_word(32'(i * 4), $urandom);
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ram_req", 64'(ram_req), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_byte", 64'(ram_byte), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wdata", 64'(out_wdata), 64'd0);
        check("rst_exc_addr", 64'(exc_addr), 64'd0);
        rst = 1'b1;

        issue(ALUSEL_OTHER, 7'h7F, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 1'b1);
        set_word(32'h100, 32'h80FF_FFFF);
        issue(ALUSEL_LOAD, OP_LB, 1'b1, 5'd7, 32'hDEAD, 32'h103, 32'h0, 2, 1'b1);
        issue(ALUSEL_STORE, OP_SH, 1'b0, 5'd0, 32'h0, 32'h102, 32'h0000_ABCD, 1, 1'b1);
        issue(ALUSEL_LOAD, OP_LW, 1'b1, 5'd9, 32'h0, 32'h105, 32'h0, 0, 1'b1);
        issue(ALUSEL_LOAD, OP_LW, 1'b1, 5'd10, 32'h0, 32'h40, 32'h0, -1, 1'b1);
        set_word(32'h0, 32'hFFFF_0000);
        issue(ALUSEL_LOAD, OP_LHU, 1'b1, 5'd0, 32'h0, 32'h2, 32'h0, 1, 1'b1);
        issue(ALUSEL_OTHER, 7'h7F, 1'b1, 5'd0, 32'h55AA, 32'h0, 32'h0, 0, 1'b1);
        issue(ALUSEL_LOAD, OP_LH, 1'b1, 5'd3, 32'h0, 32'h102, 32'h0, 3, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) random_op();
        drain();

        // Reset during REQ: the request drops at once and no writeback follows.
        issue(ALUSEL_LOAD, OP_LW, 1'b1, 5'd3, 32'h0, 32'h40, 32'h0, -2, 1'b0);
        check("req_before_rst", 64'(ram_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("req_drop_on_rst", 64'(ram_req), 64'd0);
        check("in_ready_on_rst", 64'(in_ready), 64'd1);
        check("exc_addr_on_rst", 64'(exc_addr), 64'd0);
        mdl_exc_addr = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_out_after_rst", 64'(out_valid), 64'd0);
        end

        for (int i = 0; i < 10; i++) random_op();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
